// File: rtl/pc_gen_ras.sv
// Fetch PC generator: prioritised redirects, mixed 16/32-bit sequential stepping,
// a circular return address stack and a misaligned-target fault state.
module pc_gen_ras #(
   parameter int unsigned          PC_WIDTH   = 16,
   parameter logic [PC_WIDTH-1:0]  PC_RESET   = {PC_WIDTH{1'b0}},
   parameter int unsigned          RAS_DEPTH  = 4,
   parameter int unsigned          INC_NARROW = 2,
   parameter int unsigned          INC_WIDE   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      fetch_valid,
   input  logic                      fetch_ready,
   input  logic                      fetch_wide,
   output logic [PC_WIDTH-1:0]       fetch_pc,
   input  logic                      exc_valid,
   input  logic [PC_WIDTH-1:0]       exc_vector,
   input  logic                      br_valid,
   input  logic [PC_WIDTH-1:0]       br_target,
   input  logic                      jmp_valid,
   input  logic [PC_WIDTH-1:0]       jmp_target,
   input  logic                      jmp_call,
   input  logic [PC_WIDTH-1:0]       jmp_link,
   input  logic                      ret_valid,
   input  logic [PC_WIDTH-1:0]       ret_fallback,
   output logic [$clog2(RAS_DEPTH):0] ras_count,
   output logic                      ras_underflow,
   output logic                      fault,
   output logic [PC_WIDTH-1:0]       fault_addr
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [PC_WIDTH-1:0]  fault_addr_q, fault_addr_d;
   logic [PC_WIDTH-1:0]  ras_q [RAS_DEPTH];
   logic [PC_WIDTH-1:0]  ras_d [RAS_DEPTH];
   logic [PTR_W-1:0]     sp_q, sp_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 underflow_q, underflow_d;
   logic                 valid_q, valid_d;
   logic                 fault_q, fault_d;
   logic                 redirect_s;
   logic [PC_WIDTH-1:0]  target_s;
   logic [PTR_W-1:0]     top_s;

   // Next-state, redirect arbitration and RAS update.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fault_addr_d = fault_addr_q;
      ras_d        = ras_q;
      sp_d         = sp_q;
      cnt_d        = cnt_q;
      underflow_d  = 1'b0;
      redirect_s   = 1'b0;
      target_s     = pc_q;
      top_s        = sp_q - PTR_W'(1);

      case (state_q)
         ST_FAULT: begin
            if (exc_valid) begin
               pc_d    = exc_vector;
               state_d = ST_RUN;
               cnt_d   = '0;
               sp_d    = '0;
            end else begin
               state_d = ST_FAULT;
            end
         end
         ST_BOOT, ST_RUN: begin
            if (exc_valid) begin
               pc_d    = exc_vector;
               state_d = ST_RUN;
               cnt_d   = '0;
               sp_d    = '0;
            end else if (br_valid) begin
               redirect_s = 1'b1;
               target_s   = br_target;
            end else if (jmp_valid) begin
               redirect_s = 1'b1;
               target_s   = jmp_target;
               // sp always points at the next slot, so a full stack overwrites its oldest entry
               if (jmp_call) begin
                  ras_d[sp_q] = jmp_link;
                  sp_d        = sp_q + PTR_W'(1);
                  if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end else begin
                     cnt_d = cnt_q;
                  end
               end else begin
                  sp_d = sp_q;
               end
            end else if (ret_valid) begin
               redirect_s = 1'b1;
               if (cnt_q != CNT_W'(0)) begin
                  target_s = ras_q[top_s];
                  sp_d     = top_s;
                  cnt_d    = cnt_q - CNT_W'(1);
               end else begin
                  target_s    = ret_fallback;
                  underflow_d = 1'b1;
               end
            end else begin
               state_d = ST_RUN;
               if ((state_q == ST_RUN) && fetch_ready) begin
                  pc_d = pc_q + (fetch_wide ? PC_WIDTH'(INC_WIDE) : PC_WIDTH'(INC_NARROW));
               end else begin
                  pc_d = pc_q;
               end
            end

            if (redirect_s) begin
               if (target_s[0]) begin
                  state_d      = ST_FAULT;
                  fault_addr_d = target_s;
               end else begin
                  state_d = ST_RUN;
                  pc_d    = target_s;
               end
            end else begin
               fault_addr_d = fault_addr_q;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      valid_d = (state_d == ST_RUN);
      fault_d = (state_d == ST_FAULT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_BOOT;
         pc_q         <= PC_RESET;
         fault_addr_q <= '0;
         sp_q         <= '0;
         cnt_q        <= '0;
         underflow_q  <= 1'b0;
         valid_q      <= 1'b0;
         fault_q      <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fault_addr_q <= fault_addr_d;
         sp_q         <= sp_d;
         cnt_q        <= cnt_d;
         underflow_q  <= underflow_d;
         valid_q      <= valid_d;
         fault_q      <= fault_d;
         ras_q        <= ras_d;
      end
   end

   assign fetch_valid   = valid_q;
   assign fetch_pc      = pc_q;
   assign ras_count     = cnt_q;
   assign ras_underflow = underflow_q;
   assign fault         = fault_q;
   assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: directed stimulus pushes hand-computed expectations,
// an independent monitor pops and compares one entry per cycle after each clock edge.
module tb_pc_gen_ras;

   logic        clk;
   logic        rst;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        fetch_wide;
   logic [15:0] fetch_pc;
   logic        exc_valid;
   logic [15:0] exc_vector;
   logic        br_valid;
   logic [15:0] br_target;
   logic        jmp_valid;
   logic [15:0] jmp_target;
   logic        jmp_call;
   logic [15:0] jmp_link;
   logic        ret_valid;
   logic [15:0] ret_fallback;
   logic [2:0]  ras_count;
   logic        ras_underflow;
   logic        fault;
   logic [15:0] fault_addr;

   typedef struct {
      int          id;
      logic        v;
      logic [15:0] pc;
      logic [2:0]  cnt;
      logic        uf;
      logic        f;
      logic [15:0] fa;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   pc_gen_ras dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_valid  (fetch_valid),
      .fetch_ready  (fetch_ready),
      .fetch_wide   (fetch_wide),
      .fetch_pc     (fetch_pc),
      .exc_valid    (exc_valid),
      .exc_vector   (exc_vector),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .jmp_valid    (jmp_valid),
      .jmp_target   (jmp_target),
      .jmp_call     (jmp_call),
      .jmp_link     (jmp_link),
      .ret_valid    (ret_valid),
      .ret_fallback (ret_fallback),
      .ras_count    (ras_count),
      .ras_underflow(ras_underflow),
      .fault        (fault),
      .fault_addr   (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare DUT outputs against the oldest expectation, 1 time unit after each edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (fetch_valid !== e.v || fetch_pc !== e.pc || ras_count !== e.cnt ||
             ras_underflow !== e.uf || fault !== e.f || fault_addr !== e.fa) begin
            errors++;
            $display("FAIL step%0d: got v=%0b pc=%h cnt=%0d uf=%0b f=%0b fa=%h, want v=%0b pc=%h cnt=%0d uf=%0b f=%0b fa=%h",
                     e.id, fetch_valid, fetch_pc, ras_count, ras_underflow, fault, fault_addr,
                     e.v, e.pc, e.cnt, e.uf, e.f, e.fa);
         end
      end
   end

   task automatic idle();
      exc_valid = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0; jmp_call = 1'b0; ret_valid = 1'b0;
   endtask

   // Push the expected post-edge state, then advance to the next negedge.
   task automatic chk(input int id, input logic v, input logic [15:0] pc, input logic [2:0] cnt,
                      input logic uf, input logic f, input logic [15:0] fa);
      exp_t e;
      e.id = id; e.v = v; e.pc = pc; e.cnt = cnt; e.uf = uf; e.f = f; e.fa = fa;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] links [5];
      logic [15:0] rets  [4];
      links[0] = 16'h00A0; links[1] = 16'h00A2; links[2] = 16'h00A4;
      links[3] = 16'h00A6; links[4] = 16'h00A8;
      rets[0]  = 16'h00A8; rets[1]  = 16'h00A6; rets[2]  = 16'h00A4; rets[3] = 16'h00A2;

      idle();
      exc_vector = 16'h0000; br_target = 16'h0000; jmp_target = 16'h0000;
      jmp_link = 16'h0000; ret_fallback = 16'h0000;
      fetch_ready = 1'b1; fetch_wide = 1'b0;

      // 1: reset, BOOT, then narrow stepping
      rst = 1'b1;
      chk(1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
      rst = 1'b0;
      chk(2, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
      chk(3, 1'b1, 16'h0002, 3'd0, 1'b0, 1'b0, 16'h0000);
      chk(4, 1'b1, 16'h0004, 3'd0, 1'b0, 1'b0, 16'h0000);
      chk(5, 1'b1, 16'h0006, 3'd0, 1'b0, 1'b0, 16'h0000);

      // 2: mixed lengths from 0x0010, then stall
      br_valid = 1'b1; br_target = 16'h0010;
      chk(6, 1'b1, 16'h0010, 3'd0, 1'b0, 1'b0, 16'h0000);
      idle(); fetch_wide = 1'b1;
      chk(7, 1'b1, 16'h0014, 3'd0, 1'b0, 1'b0, 16'h0000);
      fetch_wide = 1'b0;
      chk(8, 1'b1, 16'h0016, 3'd0, 1'b0, 1'b0, 16'h0000);
      fetch_wide = 1'b1;
      chk(9, 1'b1, 16'h001A, 3'd0, 1'b0, 1'b0, 16'h0000);
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) chk(10 + i, 1'b1, 16'h001A, 3'd0, 1'b0, 1'b0, 16'h0000);
      fetch_ready = 1'b1; fetch_wide = 1'b0;

      // 3: one call, then exc+br+jmp(call) together: exc wins, RAS cleared
      jmp_valid = 1'b1; jmp_call = 1'b1; jmp_target = 16'h0050; jmp_link = 16'h001E;
      chk(13, 1'b1, 16'h0050, 3'd1, 1'b0, 1'b0, 16'h0000);
      exc_valid = 1'b1; exc_vector = 16'h0100; br_valid = 1'b1; br_target = 16'h0200;
      jmp_target = 16'h0300; jmp_link = 16'h0055;
      chk(14, 1'b1, 16'h0100, 3'd0, 1'b0, 1'b0, 16'h0000);
      idle();

      // 4: five calls overflow a 4-deep RAS, five returns
      for (int i = 0; i < 5; i++) begin
         jmp_valid = 1'b1; jmp_call = 1'b1; jmp_target = 16'h0200; jmp_link = links[i];
         chk(15 + i, 1'b1, 16'h0200, (i < 4) ? 3'(i + 1) : 3'd4, 1'b0, 1'b0, 16'h0000);
      end
      idle(); ret_fallback = 16'h0300;
      for (int i = 0; i < 4; i++) begin
         ret_valid = 1'b1;
         chk(20 + i, 1'b1, rets[i], 3'(3 - i), 1'b0, 1'b0, 16'h0000);
      end
      chk(24, 1'b1, 16'h0300, 3'd0, 1'b1, 1'b0, 16'h0000);
      idle();
      chk(25, 1'b1, 16'h0302, 3'd0, 1'b0, 1'b0, 16'h0000);

      // 5: misaligned jump -> FAULT; br ignored; exc recovers
      jmp_valid = 1'b1; jmp_target = 16'h0123;
      chk(26, 1'b0, 16'h0302, 3'd0, 1'b0, 1'b1, 16'h0123);
      idle(); br_valid = 1'b1; br_target = 16'h0400;
      chk(27, 1'b0, 16'h0302, 3'd0, 1'b0, 1'b1, 16'h0123);
      idle(); exc_valid = 1'b1; exc_vector = 16'h0040;
      chk(28, 1'b1, 16'h0040, 3'd0, 1'b0, 1'b0, 16'h0123);
      idle();
      chk(29, 1'b1, 16'h0042, 3'd0, 1'b0, 1'b0, 16'h0123);

      // 6: wrap at 0xFFFE, then mid-run reset invalidates the RAS
      br_valid = 1'b1; br_target = 16'hFFFE;
      chk(30, 1'b1, 16'hFFFE, 3'd0, 1'b0, 1'b0, 16'h0123);
      idle();
      chk(31, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0123);
      jmp_valid = 1'b1; jmp_call = 1'b1; jmp_target = 16'h0600; jmp_link = 16'h0077;
      chk(32, 1'b1, 16'h0600, 3'd1, 1'b0, 1'b0, 16'h0123);
      idle(); rst = 1'b1;
      chk(33, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
      rst = 1'b0;
      chk(34, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
      ret_valid = 1'b1; ret_fallback = 16'h0700;
      chk(35, 1'b1, 16'h0700, 3'd0, 1'b1, 1'b0, 16'h0000);
      idle();

      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
